cache_dm_line: RTL
==================

# cache_dm_line

Parametrised, synthesizable direct-mapped cache sitting between the CPU data port and the external SRAM controller on the board model. It generalises the single-word behavioural cache to multi-word lines filled by a memory burst, with arbitrary byte-enable writes. Policy is write-through, no-write-allocate. CPU and memory sides use the same request/grant/ready handshake as the rest of the board; inout buses are split into separate read and write buses.

## Interface
- SET_BITS, 7: log2 of set count (128 sets).
- WORD_BITS, 2: log2 of 32-bit words per line (4 words, 16 bytes).
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- read  in  1  CPU read request; held until `ready`.
- write  in  4  CPU byte enables, [3]=bits 31:24; nonzero = write request.
- adbus  in  32  CPU byte address; bits 1:0 ignored.
- databus_in  in  32  CPU write data.
- databus_out  out  32  CPU read data; valid while `ready` is high on a read.
- ready  out  1  transfer complete; held until the request drops.
- grant  out  1  request accepted; high from acceptance until return to IDLE.
- read_mem / write_mem  out  1  memory requests.
- grant_mem  in  1  memory accepts the request.
- ready_mem  in  1  one-cycle pulse per completed memory word.
- mem_adbus  out  32  memory word address, word-aligned.
- mem_databus_in  in  32  fill data; sampled when `ready_mem` is high.
- mem_databus_out  out  32  write-through data.
- mem_be  out  4  byte enables for write-through, copied from `write`.

## Operation
- Address split: offset=adbus[WORD_BITS+1:2]; set=adbus[SET_BITS+WORD_BITS+1:WORD_BITS+2]; tag=the remaining upper bits.
- Per set: data line, tag and valid. `reset` clears every valid bit in one cycle.
- FSM states:
  - IDLE: request present → compare. If `write` is nonzero, go to WT, even when `read` is also high. Else if `read` hits, go to DONE with `databus_out` = ram[set][offset]. Else go to FILL.
  - FILL: assert `read_mem`. Once `grant_mem` is seen, drive `mem_adbus` = {tag, set, k, 2'b00} for k = 0..2^WORD_BITS-1.
    - Each `ready_mem` pulse writes word k and increments k.
    - After the last word: set valid and tag, drop `read_mem`, load `databus_out` from the filled line at `offset`, go to DONE.
  - WT: on entry, a hit merges the enabled bytes into the line (valid unchanged). A miss leaves the cache untouched. Then assert `write_mem` with `mem_adbus` = {adbus[31:2],2'b00}, `mem_databus_out` = `databus_in` and `mem_be` = `write`. On `ready_mem`, drop `write_mem` and go to DONE.
  - DONE: `ready`=1 until both `read`=0 and `write`=0, then go to IDLE, where `ready` and `grant` go to 0.
- Any byte-enable pattern is legal, including non-contiguous ones.

## Timing
- Reset values: ready=0, grant=0, read_mem=0, write_mem=0, databus_out=0, mem_adbus=0, mem_databus_out=0, mem_be=0, FSM=IDLE, k=0.
- Read hit: request sampled at edge N → `grant`, `ready` and data valid after edge N+1 (1-cycle latency).
- Read miss: `read_mem` rises after edge N+1 and stays high for the whole burst. `ready` rises one cycle after the last `ready_mem`.
- `ready_mem` arriving before `grant_mem` is ignored.
- Write: `ready` rises one cycle after `ready_mem`.
- Request dropped before `ready`: protocol violation. The block still completes the memory transaction.
- Reset mid-FILL or mid-WT: memory strobes drop on the next edge, a partial line never becomes valid, and the FSM returns to IDLE.
- Offset wrap: the burst always starts at word 0. There is no critical-word-first ordering.

## Configuration
- CACHE_STATS_EN defined: adds output ports `hit_count` and `miss_count`, each 32-bit, cleared by `reset`.
  - Each counter increments once per accepted request in IDLE, reads and writes alike.
  - Counters wrap at 2^32.
- CACHE_STATS_EN undefined: no counter ports and no counter logic.

## Test plan
- Reset, then read 0x0000_0040 with memory returning 0x11,0x22,0x33,0x44 → four `ready_mem` pulses at mem_adbus 0x40,0x44,0x48,0x4C; databus_out=0x11. A follow-up read of 0x48 hits in 1 cycle with 0x33 and no `read_mem`.
- Write 0x0000_0044, write=4'b0101, data 0xAABBCCDD, on a valid line holding 0x22 → mem_be=0101; a later read of 0x44 returns 0x00BB00DD.
- Write miss to 0x0000_2000, then read 0x2000 → the write produces no cache change, and the read triggers a full fill.
- Two addresses 0x0040 and 0x0840 (same set, different tag) read alternately → every access is a miss with a 4-word burst.
- Assert `reset` after the second `ready_mem` of a fill, then read the same address → a new 4-word fill starts at word 0.
- CACHE_STATS_EN build: run the first scenario → hit_count=1, miss_count=1.

Source files
------------

// File: rtl/cache_dm_line.sv
// Direct-mapped, write-through / no-write-allocate cache with multi-word line fill by memory burst.
// Optional hit/miss counters are included when CACHE_STATS_EN is defined.
module cache_dm_line #(
  parameter int SET_BITS  = 7,
  parameter int WORD_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic [3:0]  write,
  input  logic [31:0] adbus,
  input  logic [31:0] databus_in,
  output logic [31:0] databus_out,
  output logic        ready,
  output logic        grant,
  output logic        read_mem,
  output logic        write_mem,
  input  logic        grant_mem,
  input  logic        ready_mem,
  output logic [31:0] mem_adbus,
  input  logic [31:0] mem_databus_in,
  output logic [31:0] mem_databus_out,
  output logic [3:0]  mem_be
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  // state | meaning
  // IDLE  | wait for a CPU request, look up the set
  // FILL  | burst-read the whole line from memory, word 0 first
  // WT    | write-through of one word to memory
  // DONE  | hold ready until the CPU drops its request
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WT, S_DONE} state_t;

  localparam int SETS     = 1 << SET_BITS;
  localparam int WORDS    = 1 << WORD_BITS;
  localparam int TAG_BITS = 30 - SET_BITS - WORD_BITS;
  localparam int IDX_BITS = SET_BITS + WORD_BITS;

  state_t                r_state;
  logic [WORD_BITS-1:0]  r_k;
  logic                  r_gnt;
  logic [WORD_BITS-1:0]  r_off;
  logic [SET_BITS-1:0]   r_set;
  logic [TAG_BITS-1:0]   r_tag;
  logic [SETS-1:0]       r_valid;
  logic [TAG_BITS-1:0]   r_tag_arr [SETS];
  logic [31:0]           r_data    [SETS*WORDS];

  logic [WORD_BITS-1:0]  w_off;
  logic [SET_BITS-1:0]   w_set;
  logic [TAG_BITS-1:0]   w_tag;
  logic [IDX_BITS-1:0]   w_hit_idx;
  logic [IDX_BITS-1:0]   w_fill_idx;
  logic [IDX_BITS-1:0]   w_line_idx;
  logic [WORD_BITS-1:0]  w_k_next;
  logic                  w_req;
  logic                  w_is_wr;
  logic                  w_hit;
  logic                  w_gnt;
  logic                  w_idle_accept;
  logic                  w_fill_we;
  logic                  w_fill_last;
  logic                  w_merge_we;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_line_word;
  logic [31:0]           w_merge_word;
  logic                  w_unused_ok;

  assign w_off         = adbus[WORD_BITS+1:2];
  assign w_set         = adbus[SET_BITS+WORD_BITS+1:WORD_BITS+2];
  assign w_tag         = adbus[31:SET_BITS+WORD_BITS+2];
  assign w_unused_ok   = &{1'b0, adbus[1:0]};
  assign w_hit_idx     = {w_set, w_off};
  assign w_fill_idx    = {r_set, r_k};
  assign w_line_idx    = {r_set, r_off};
  assign w_k_next      = r_k + WORD_BITS'(1);
  assign w_req         = read | (|write);
  assign w_is_wr       = |write;
  assign w_hit         = r_valid[w_set] && (r_tag_arr[w_set] == w_tag);
  // grant_mem in the same cycle as ready_mem counts; ready_mem before any grant does not
  assign w_gnt         = r_gnt | grant_mem;
  assign w_idle_accept = (r_state == S_IDLE) && w_req;
  assign w_fill_we     = (r_state == S_FILL) && w_gnt && ready_mem;
  assign w_fill_last   = w_fill_we && (&r_k);
  assign w_merge_we    = w_idle_accept && w_is_wr && w_hit;
  assign w_rd_word     = r_data[w_hit_idx];
  assign w_line_word   = r_data[w_line_idx];

  always_comb begin
    w_merge_word = w_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (write[b]) w_merge_word[8*b +: 8] = databus_in[8*b +: 8];
    end
  end

  // Line data and tags carry no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_fill_we)   r_data[w_fill_idx] <= mem_databus_in;
      if (w_merge_we)  r_data[w_hit_idx]  <= w_merge_word;
      if (w_fill_last) r_tag_arr[r_set]   <= r_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_k             <= '0;
      r_gnt           <= 1'b0;
      r_off           <= '0;
      r_set           <= '0;
      r_tag           <= '0;
      r_valid         <= '0;
      ready           <= 1'b0;
      grant           <= 1'b0;
      read_mem        <= 1'b0;
      write_mem       <= 1'b0;
      databus_out     <= '0;
      mem_adbus       <= '0;
      mem_databus_out <= '0;
      mem_be          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            grant <= 1'b1;
            r_off <= w_off;
            r_set <= w_set;
            r_tag <= w_tag;
            r_gnt <= 1'b0;
            r_k   <= '0;
            if (w_is_wr) begin
              r_state         <= S_WT;
              write_mem       <= 1'b1;
              mem_adbus       <= {adbus[31:2], 2'b00};
              mem_databus_out <= databus_in;
              mem_be          <= write;
            end else if (w_hit) begin
              r_state     <= S_DONE;
              ready       <= 1'b1;
              databus_out <= w_rd_word;
            end else begin
              r_state   <= S_FILL;
              read_mem  <= 1'b1;
              mem_adbus <= {w_tag, w_set, {WORD_BITS{1'b0}}, 2'b00};
            end
          end
        end
        S_FILL: begin
          if (grant_mem) r_gnt <= 1'b1;
          if (w_fill_we) begin
            if (&r_k) begin
              r_valid[r_set] <= 1'b1;
              read_mem       <= 1'b0;
              ready          <= 1'b1;
              databus_out    <= (r_off == r_k) ? mem_databus_in : w_line_word;
              r_k            <= '0;
              r_state        <= S_DONE;
            end else begin
              r_k       <= w_k_next;
              mem_adbus <= {r_tag, r_set, w_k_next, 2'b00};
            end
          end
        end
        S_WT: begin
          if (grant_mem) r_gnt <= 1'b1;
          if (w_gnt && ready_mem) begin
            write_mem <= 1'b0;
            ready     <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (!w_req) begin
            ready   <= 1'b0;
            grant   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_idle_accept) begin
      if (w_hit) hit_count  <= hit_count + 32'd1;
      else       miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
